// File: rtl/arb_resp_pkg.sv
// Shared types and sizing helpers for the arbiter response router.
package arb_resp_pkg;

  function automatic int unsigned idx_width(input int unsigned num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DefaultNumIn = 4;

  typedef logic [idx_width(DefaultNumIn)-1:0] idx_t;

endpackage

// File: rtl/fifo_v3.sv
// Circular FIFO with occupancy count; pointers wrap at DEPTH-1 so any DEPTH >= 1 works.
module fifo_v3
  import arb_resp_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PtrWidth     = ptr_width(DEPTH),
  parameter int unsigned CntWidth     = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CntWidth-1:0]   usage_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrWidth-1:0]   rptr;
  logic [PtrWidth-1:0]   wptr;
  logic [CntWidth-1:0]   count;
  logic                  push_eff;
  logic                  pop_eff;
  logic                  pass_through;

  assign full_o  = (count == CntWidth'(DEPTH));
  assign empty_o = (count == '0);
  assign usage_o = count;

  // In fall-through mode an entry pushed and popped while empty is never stored.
  assign pass_through = FALL_THROUGH & empty_o & push_i & pop_i;
  assign push_eff     = push_i & ~full_o & ~pass_through;
  assign pop_eff      = pop_i & ~empty_o;
  assign data_o       = (FALL_THROUGH && empty_o) ? data_i : mem[rptr];

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) wptr <= ptr_next(wptr);
      if (pop_eff)  rptr <= ptr_next(rptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff && !flush_i) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/arb_resp_router.sv
// Gates arbiter requests into a slave and routes in-order responses back by queued index.
// Optional ARB_RESP_ROUTER_BYPASS_EN routes a response in the same cycle as its request when the queue is empty.
module arb_resp_router
  import arb_resp_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        arb_req_i,
  input  logic [IdxWidth-1:0]         arb_idx_i,
  output logic                        arb_gnt_o,
  output logic                        slv_req_o,
  input  logic                        slv_gnt_i,
  input  logic                        slv_rsp_valid_i,
  output logic                        slv_rsp_ready_o,
  input  logic [DataWidth-1:0]        slv_rsp_data_i,
  output logic [NumIn-1:0]            rsp_valid_o,
  input  logic [NumIn-1:0]            rsp_ready_i,
  output logic [DataWidth-1:0]        rsp_data_o,
  output logic [cnt_width(Depth)-1:0] usage_o,
  output logic                        full_o,
  output logic                        empty_o
);

  logic                push_hs;
  logic                pop_hs;
  logic                bypass_act;
  logic                fifo_push;
  logic                fifo_pop;
  logic [IdxWidth-1:0] head_idx;
  logic [IdxWidth-1:0] sel_idx;
  logic                sel_en;

  // full_o comes from registered occupancy, so a pop never frees a slot for the same cycle's push.
  assign slv_req_o  = arb_req_i & ~full_o;
  assign arb_gnt_o  = slv_gnt_i & ~full_o;
  assign push_hs    = slv_req_o & slv_gnt_i;
  assign pop_hs     = slv_rsp_valid_i & slv_rsp_ready_o;
  assign rsp_data_o = slv_rsp_data_i;

`ifdef ARB_RESP_ROUTER_BYPASS_EN
  assign bypass_act = empty_o & push_hs;
`else
  assign bypass_act = 1'b0;
`endif

  assign fifo_push = push_hs & ~(bypass_act & pop_hs);
  assign fifo_pop  = pop_hs & ~empty_o;

  always_comb begin
    rsp_valid_o     = '0;
    slv_rsp_ready_o = 1'b0;
    sel_idx         = head_idx;
    sel_en          = ~empty_o;
    if (bypass_act) begin
      sel_idx = arb_idx_i;
      sel_en  = 1'b1;
    end
    if (sel_en) begin
      for (int i = 0; i < NumIn; i++) begin
        if (sel_idx == IdxWidth'(i)) begin
          rsp_valid_o[i]  = slv_rsp_valid_i;
          slv_rsp_ready_o = rsp_ready_i[i];
        end
      end
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxWidth),
    .DEPTH        (Depth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .data_i  (arb_idx_i),
    .pop_i   (fifo_pop),
    .data_o  (head_idx),
    .usage_o (usage_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(rsp_valid_o));
      assert (!(pop_hs && empty_o && !bypass_act));
    end
  end
`endif

endmodule

// File: doc/arb_resp_router.md
ARB_RESP_ROUTER -- requirements
Module: arb_resp_router

Interface
REQ-001 SHALL have parameter NumIn, default 4: number of arbitrated inputs (>=1).
REQ-002 SHALL have parameter DataWidth, default 32: response payload width.
REQ-003 SHALL have parameter Depth, default 4: maximum outstanding transactions (>=1, any integer).
REQ-004 SHALL have parameter IdxWidth, default (NumIn>1 ? clog2(NumIn) : 1): derived, not overridden.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk_i  in  1  clock, rising edge; rst_ni  in  1  asynchronous reset, active low.
REQ-006 SHALL have ports: flush_i  in  1  synchronous clear of outstanding state.
REQ-007 SHALL have ports: arb_req_i  in  1  arbiter output request; arb_idx_i  in  IdxWidth  winning input index; arb_gnt_o  out  1  grant back to arbiter.
REQ-008 SHALL have ports: slv_req_o  out  1  request to slave; slv_gnt_i  in  1  slave grant.
REQ-009 SHALL have ports: slv_rsp_valid_i  in  1; slv_rsp_ready_o  out  1; slv_rsp_data_i  in  DataWidth  in-order slave response.
REQ-010 SHALL have ports: rsp_valid_o  out  NumIn; rsp_ready_i  in  NumIn; rsp_data_o  out  DataWidth  per-input response (data broadcast).
REQ-011 SHALL have ports: usage_o  out  clog2(Depth+1)  outstanding count; full_o  out  1; empty_o  out  1.

Function
REQ-012 SHALL be a request gate plus in-order index queue: requests pass downstream, indices of accepted requests are queued, responses routed back by queue head.
REQ-013 SHALL drive slv_req_o = arb_req_i & ~full_o and arb_gnt_o = slv_gnt_i & ~full_o, combinationally.
REQ-014 SHALL push arb_idx_i on every cycle with slv_req_o & slv_gnt_i (push handshake).
REQ-015 SHALL, when not empty, drive rsp_valid_o[head] = slv_rsp_valid_i, all other bits 0, and slv_rsp_ready_o = rsp_ready_i[head].
REQ-016 SHALL pop the head on slv_rsp_valid_i & slv_rsp_ready_o (pop handshake); rsp_data_o = slv_rsp_data_i always.
REQ-017 SHALL, when empty (and bypass absent/inactive), drive rsp_valid_o = 0 and slv_rsp_ready_o = 0.
REQ-018 SHALL, on simultaneous push and pop, leave usage_o unchanged and advance both pointers.
REQ-019 SHALL, when full, block pushes via REQ-013; a same-cycle pop does not unblock that cycle's push (full_o registered-derived, no combinational ready-through).
REQ-020 SHALL wrap read/write pointers from Depth-1 to 0; full_o = (usage_o == Depth), empty_o = (usage_o == 0).
REQ-021 SHALL make push latency one cycle: an index pushed in cycle N is routable from cycle N+1.
REQ-022 SHALL, on flush_i, clear pointers and count next edge; flush has priority over push/pop in that cycle; outputs during flush cycle follow current state.

Reset
REQ-023 SHALL reset asynchronously: pointers 0, usage_o 0, empty_o 1, full_o 0, rsp_valid_o 0, slv_rsp_ready_o 0; queue storage need not be reset.
REQ-024 SHALL, when reset asserts mid-transaction, drop all outstanding indices; later responses are ignored (ready 0 while empty).

Configuration
REQ-025 SHALL support macro ARB_RESP_ROUTER_BYPASS_EN: when defined and queue empty, a same-cycle push handshake routes slv_rsp_valid_i to rsp_valid_o[arb_idx_i]; if the response also pops, nothing is stored and usage_o stays 0.
REQ-026 SHALL, without ARB_RESP_ROUTER_BYPASS_EN, have minimum one-cycle request-to-response latency per REQ-017/REQ-021.

Structure
REQ-027 SHALL place idx_t and the Depth/count-width helper function in shared package arb_resp_pkg.
REQ-028 SHALL use one sub-module, fifo_v3 (DEPTH=Depth, FALL_THROUGH=0), as index queue; bypass and gating logic in the top module.
REQ-029 SHALL assert (simulation only) onehot0(rsp_valid_o) and no pop while empty.

Verification
REQ-030 Reset mid-stream: 3 outstanding, pulse rst_ni -> usage_o 0, empty_o 1, slv_rsp_ready_o 0 next cycle.
REQ-031 Order: NumIn=4, Depth=4, push idx 2,0,3 -> responses D0,D1,D2 appear on rsp_valid_o[2],[0],[3] in order.
REQ-032 Full: 4 pushes, no responses -> full_o 1, arb_gnt_o 0 with slv_gnt_i 1; one pop -> arb_gnt_o 1 next cycle.
REQ-033 Simultaneous push/pop at usage 2 -> usage_o stays 2; pointers wrap correctly across 6 cycles of continuous push/pop.
REQ-034 Back-pressure: head idx 1, rsp_ready_i[1]=0 for 3 cycles -> slv_rsp_ready_o 0, no pop, rsp_valid_o=4'b0010 held.
REQ-035 Bypass (macro defined): empty, push idx 3 with same-cycle response -> rsp_valid_o=4'b1000, usage_o stays 0; undefined -> rsp_valid_o 0 that cycle, routed next cycle.
